// File: rtl/inst_line_fetch.sv
// Instruction fetch responder backed by a single-line prefetch buffer.
// Misses refill the whole line from a slow backing memory via req/ack.
module inst_line_fetch #(
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        stallreq,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = 30 - OFF_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

  typedef enum logic {IDLE, REFILL} state_t;

  state_t             state_reg, state_next;
  logic [31:0]        line_buf [LINE_WORDS];
  logic [TAG_W-1:0]   line_tag_reg;
  logic [TAG_W-1:0]   refill_tag_reg;
  logic               line_valid_reg;
  logic               flush_pend_reg;
  logic [OFF_W-1:0]   word_cnt_reg;

  logic [TAG_W-1:0]   pc_tag;
  logic [OFF_W-1:0]   pc_off;
  logic               hit;
  logic               miss;
  logic               word_take;
  logic               last_take;
  logic               unused_pc_bits;

  assign pc_tag         = pc[31:OFF_W+2];
  assign pc_off         = pc[OFF_W+1:2];
  assign unused_pc_bits = ^pc[1:0];

  assign hit       = ce && line_valid_reg && (pc_tag == line_tag_reg) && (state_reg == IDLE);
  assign miss      = ce && !hit && (state_reg == IDLE);
  assign word_take = (state_reg == REFILL) && mem_ack;
  assign last_take = word_take && (word_cnt_reg == LAST_WORD);

  assign inst     = hit ? line_buf[pc_off] : 32'h0;
  assign stallreq = ce && !hit;
  assign mem_req  = (state_reg == REFILL);
  assign mem_addr = {refill_tag_reg, word_cnt_reg, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (miss) state_next = REFILL;
      REFILL:  if (last_take) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A flush seen during a refill is remembered so the completed line lands invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_tag_reg   <= '0;
      refill_tag_reg <= '0;
      line_valid_reg <= 1'b0;
      flush_pend_reg <= 1'b0;
      word_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (miss) begin
            refill_tag_reg <= pc_tag;
            word_cnt_reg   <= '0;
            line_valid_reg <= 1'b0;
          end else if (flush) begin
            line_valid_reg <= 1'b0;
          end
        end
        REFILL: begin
          if (flush) flush_pend_reg <= 1'b1;
          if (word_take) word_cnt_reg <= word_cnt_reg + 1'b1;
          if (last_take) begin
            line_tag_reg   <= refill_tag_reg;
            line_valid_reg <= !flush_pend_reg && !flush;
            flush_pend_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage has no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (!rst && word_take) line_buf[word_cnt_reg] <= mem_rdata;
  end

endmodule
